nios_system_input_debouncer: RTL and testbench

//  Input conditioner between the board's raw switches/buttons and the 8-bit

---
 rtl/nios_system_input_debouncer_if.sv | 40 ++++
 rtl/nios_system_input_debouncer.sv | 113 +++++++++++
 tb/tb_nios_system_input_debouncer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/nios_system_input_debouncer_if.sv
`default_nettype none
// ============================================================================
//  Module      : nios_system_input_debouncer_if
//  Description : Signal bundle between raw board inputs, the debouncer and
//                the PIO / edge-capture consumers.
//  Revision    : 1.0 - initial release
// ============================================================================
interface nios_system_input_debouncer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] raw_in;
    logic             clear_edges;
    logic [WIDTH-1:0] clear_mask;
    logic [WIDTH-1:0] debounced_out;
    logic [WIDTH-1:0] rise_pulse;
    logic [WIDTH-1:0] fall_pulse;
    logic [WIDTH-1:0] edge_capture;

    // Master drives the raw levels and the clear strobe; slave is the debouncer.
    modport master (
        output raw_in,
        output clear_edges,
        output clear_mask,
        input  debounced_out,
        input  rise_pulse,
        input  fall_pulse,
        input  edge_capture
    );

    modport slave (
        input  raw_in,
        input  clear_edges,
        input  clear_mask,
        output debounced_out,
        output rise_pulse,
        output fall_pulse,
        output edge_capture
    );
endinterface
`default_nettype wire

// File: rtl/nios_system_input_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : nios_system_input_debouncer
//  Description : Per-bit 2-flop synchroniser and stability-counter debouncer
//                with rise/fall strobes and a sticky rising-edge register.
//  Revision    : 1.0 - initial release
// ============================================================================
module nios_system_input_debouncer #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  wire logic                       clk,
    input  wire logic                       reset,
    nios_system_input_debouncer_if.slave    bus
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_deb;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic [WIDTH-1:0] r_capture;

    logic [WIDTH-1:0] w_accept;
    logic [WIDTH-1:0] w_rise_next;
    logic [WIDTH-1:0] w_fall_next;
    logic [WIDTH-1:0] w_clear_bits;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.raw_in;
            r_sync2 <= r_sync1;
        end
    end

    // State is implied by whether the synchronised level disagrees with the
    // accepted level; only the counter itself needs storage.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_next;
        state_t           w_state;
        logic             w_acc;

        always_comb begin
            w_state    = (r_sync2[i] != r_deb[i]) ? ST_PENDING : ST_STABLE;
            w_cnt_next = '0;
            w_acc      = 1'b0;
            case (w_state)
                ST_STABLE: begin
                    w_cnt_next = '0;
                end
                ST_PENDING: begin
                    if (r_cnt == c_LAST) begin
                        w_acc = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_cnt_next = '0;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= w_cnt_next;
            end
        end

        assign w_accept[i] = w_acc;
    end

    // On acceptance the new level is the synchronised one, so its value
    // alone tells rising from falling.
    assign w_rise_next  = w_accept & r_sync2;
    assign w_fall_next  = w_accept & ~r_sync2;
    assign w_clear_bits = bus.clear_edges ? bus.clear_mask : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_deb     <= '0;
            r_rise    <= '0;
            r_fall    <= '0;
            r_capture <= '0;
        end else begin
            r_deb     <= r_deb ^ w_accept;
            r_rise    <= w_rise_next;
            r_fall    <= w_fall_next;
            r_capture <= (r_capture & ~w_clear_bits) | w_rise_next;
        end
    end

    assign bus.debounced_out = r_deb;
    assign bus.rise_pulse    = r_rise;
    assign bus.fall_pulse    = r_fall;
    assign bus.edge_capture  = r_capture;

endmodule
`default_nettype wire

// File: tb/tb_nios_system_input_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nios_system_input_debouncer
//  Description : Directed scoreboard bench for the input debouncer (N=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nios_system_input_debouncer;

    localparam int c_WIDTH = 8;
    localparam int c_DEB   = 4;
    localparam int c_CNT_W = 3;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    nios_system_input_debouncer_if #(.WIDTH(c_WIDTH)) bus ();

    nios_system_input_debouncer #(
        .WIDTH           (c_WIDTH),
        .DEBOUNCE_CYCLES (c_DEB),
        .CNT_W           (c_CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] deb;
        logic [7:0] rise;
        logic [7:0] fall;
        logic [7:0] ec;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        assert (obs === exp_v)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push the expectation for the coming edge, advance, then pop and compare.
    task automatic step(input string tag, input logic [7:0] d, input logic [7:0] r,
                        input logic [7:0] f, input logic [7:0] e);
        exp_t x;
        exp_t y;
        x.tag = tag; x.deb = d; x.rise = r; x.fall = f; x.ec = e;
        sb.push_back(x);
        tick();
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=empty expected=entry", tag);
        end else begin
            y = sb.pop_front();
            chk({y.tag, ".deb"},  bus.debounced_out, y.deb);
            chk({y.tag, ".rise"}, bus.rise_pulse,    y.rise);
            chk({y.tag, ".fall"}, bus.fall_pulse,    y.fall);
            chk({y.tag, ".ec"},   bus.edge_capture,  y.ec);
        end
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        reset           = 1'b1;
        bus.raw_in      = 8'hFF;
        bus.clear_edges = 1'b0;
        bus.clear_mask  = 8'h00;

        // Reset with all inputs high, then acceptance at edge 6
        step("rst", 8'h00, 8'h00, 8'h00, 8'h00);
        step("rst", 8'h00, 8'h00, 8'h00, 8'h00);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) step("t1_wait", 8'h00, 8'h00, 8'h00, 8'h00);
        step("t1_acc",   8'hFF, 8'hFF, 8'h00, 8'hFF);
        step("t1_after", 8'hFF, 8'h00, 8'h00, 8'hFF);

        // Bring all bits low, then clear the capture register
        bus.raw_in = 8'h00;
        for (int k = 0; k < 5; k++) step("low_wait", 8'hFF, 8'h00, 8'h00, 8'hFF);
        step("low_acc",   8'h00, 8'h00, 8'hFF, 8'hFF);
        step("low_after", 8'h00, 8'h00, 8'h00, 8'hFF);
        bus.clear_edges = 1'b1;
        bus.clear_mask  = 8'hFF;
        step("clr_all", 8'h00, 8'h00, 8'h00, 8'h00);
        bus.clear_edges = 1'b0;
        bus.clear_mask  = 8'h00;

        // Glitch of three cycles on bit 0
        bus.raw_in = 8'h01;
        for (int k = 0; k < 3; k++) step("t2_glitch", 8'h00, 8'h00, 8'h00, 8'h00);
        bus.raw_in = 8'h00;
        for (int k = 0; k < 8; k++) step("t2_settle", 8'h00, 8'h00, 8'h00, 8'h00);

        // Bounce on bit 3, then hold high
        bus.raw_in = 8'h08; step("t3_bounce", 8'h00, 8'h00, 8'h00, 8'h00);
        bus.raw_in = 8'h00; step("t3_bounce", 8'h00, 8'h00, 8'h00, 8'h00);
        bus.raw_in = 8'h08; step("t3_bounce", 8'h00, 8'h00, 8'h00, 8'h00);
        bus.raw_in = 8'h00; step("t3_bounce", 8'h00, 8'h00, 8'h00, 8'h00);
        bus.raw_in = 8'h08;
        for (int k = 0; k < 5; k++) step("t3_wait", 8'h00, 8'h00, 8'h00, 8'h00);
        step("t3_acc",   8'h08, 8'h08, 8'h00, 8'h08);
        step("t3_after", 8'h08, 8'h00, 8'h00, 8'h08);

        // Release bit 3
        bus.raw_in = 8'h00;
        for (int k = 0; k < 5; k++) step("t4_wait", 8'h08, 8'h00, 8'h00, 8'h08);
        step("t4_fall",  8'h00, 8'h00, 8'h08, 8'h08);
        step("t4_after", 8'h00, 8'h00, 8'h00, 8'h08);

        // Build edge_capture = 09, mask ignored without the strobe
        bus.raw_in = 8'h01;
        for (int k = 0; k < 5; k++) step("t5_wait", 8'h00, 8'h00, 8'h00, 8'h08);
        step("t5_rise", 8'h01, 8'h01, 8'h00, 8'h09);
        bus.clear_mask = 8'hFF;
        step("t5_maskonly", 8'h01, 8'h00, 8'h00, 8'h09);
        bus.clear_mask = 8'h00;
        bus.raw_in = 8'h00;
        for (int k = 0; k < 5; k++) step("t5_wait2", 8'h01, 8'h00, 8'h00, 8'h09);
        step("t5_fall",  8'h00, 8'h00, 8'h01, 8'h09);
        step("t5_after", 8'h00, 8'h00, 8'h00, 8'h09);
        bus.raw_in = 8'h01;
        for (int k = 0; k < 5; k++) step("t5_wait3", 8'h00, 8'h00, 8'h00, 8'h09);
        bus.clear_edges = 1'b1;
        bus.clear_mask  = 8'h09;
        step("t5_setwins", 8'h01, 8'h01, 8'h00, 8'h01);
        bus.clear_mask  = 8'h01;
        step("t5_clr0", 8'h01, 8'h00, 8'h00, 8'h00);
        bus.clear_edges = 1'b0;
        bus.clear_mask  = 8'h00;

        // Reset while bit 5 is mid-count
        bus.raw_in = 8'h21;
        for (int k = 0; k < 4; k++) step("t6_pend", 8'h01, 8'h00, 8'h00, 8'h00);
        reset = 1'b1;
        step("t6_rst", 8'h00, 8'h00, 8'h00, 8'h00);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) step("t6_wait", 8'h00, 8'h00, 8'h00, 8'h00);
        step("t6_acc",   8'h21, 8'h21, 8'h00, 8'h21);
        step("t6_after", 8'h21, 8'h00, 8'h00, 8'h21);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
